// File: rtl/ulpi_rx_framer.sv
// rtl/ulpi_rx_framer.sv - ULPI receive framer: RX CMD decode plus SOP/EOP/ERR beat framing into a small FIFO.
// Data bytes are held one cycle so the last byte of a packet can be tagged with eop when the end event arrives.
module ulpi_rx_framer #(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rx_valid,
   input  logic       i_rx_cmd,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_end,
   output logic [7:0] o_pkt_data,
   output logic       o_pkt_sop,
   output logic       o_pkt_eop,
   output logic       o_pkt_err,
   output logic       o_pkt_valid,
   input  logic       i_pkt_ready,
   output logic [1:0] o_linestate,
   output logic [1:0] o_vbus_state,
   output logic       o_rx_active,
   output logic       o_host_disconnect,
   output logic       o_id_gnd,
   output logic       o_alt_int,
   output logic       o_overflow,
   input  logic       i_overflow_clr
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DATA} state_t;
   state_t r_state, w_state_n;

   logic [10:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;

   logic       r_hold_valid, r_hold_sop, r_err_acc, r_pkt_ovf, r_drop, r_term_pending, r_term_err;
   logic [7:0] r_hold_data;
   logic [1:0] r_linestate, r_vbus_state;
   logic       r_rx_active, r_host_disconnect, r_id_gnd, r_alt_int, r_overflow;

   logic        w_is_cmd, w_is_data, w_end, w_pop, w_full, w_can_push, w_push, w_ovf_set, w_err_val;
   logic [1:0]  w_ev;
   logic [10:0] w_push_beat, w_head;
   logic        w_hold_valid_n, w_hold_sop_n, w_err_acc_n, w_pkt_ovf_n, w_drop_n;
   logic        w_term_pending_n, w_term_err_n;
   logic [7:0]  w_hold_data_n;

   assign w_is_cmd   = i_rx_valid & i_rx_cmd;
   assign w_is_data  = i_rx_valid & ~i_rx_cmd;
   assign w_ev       = i_rx_data[5:4];
   assign w_end      = (i_rx_end & ((r_state != S_IDLE) | w_is_data)) |
                       (w_is_cmd & (r_state != S_IDLE) & ~w_ev[0]);
   assign w_full     = (r_count == (AW+1)'(DEPTH));
   assign w_pop      = o_pkt_valid & i_pkt_ready;
   assign w_can_push = ~w_full | w_pop;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      if (w_end)                                           w_state_n = S_IDLE;
      else if (w_is_data)                                  w_state_n = S_DATA;
      else if (w_is_cmd && r_state == S_IDLE && w_ev[0])   w_state_n = S_ARMED;
   end

   // Single FIFO write port per cycle: pending terminator, data-driven push, or end-driven push.
   always_comb begin
      w_hold_valid_n   = r_hold_valid;
      w_hold_sop_n     = r_hold_sop;
      w_hold_data_n    = r_hold_data;
      w_err_acc_n      = r_err_acc;
      w_pkt_ovf_n      = r_pkt_ovf;
      w_drop_n         = r_drop;
      w_term_pending_n = r_term_pending;
      w_term_err_n     = r_term_err;
      w_push           = 1'b0;
      w_push_beat      = '0;
      w_ovf_set        = 1'b0;
      w_err_val        = 1'b0;

      if (r_term_pending) begin
         if (w_can_push) begin
            w_push           = 1'b1;
            w_push_beat      = {r_hold_sop, 1'b1, r_term_err, r_hold_data};
            w_term_pending_n = 1'b0;
            w_hold_valid_n   = 1'b0;
         end else if (!r_term_err) begin
            w_term_err_n = 1'b1;
            w_ovf_set    = 1'b1;
         end
      end

      if (w_is_data) begin
         if (r_state != S_DATA) begin
            if (r_term_pending) begin
               w_drop_n  = 1'b1;
               w_ovf_set = 1'b1;
            end else begin
               w_hold_valid_n = 1'b1;
               w_hold_sop_n   = 1'b1;
               w_hold_data_n  = i_rx_data;
            end
         end else if (r_drop || r_pkt_ovf) begin
            w_ovf_set = 1'b1;
         end else begin
            w_push      = w_can_push;
            w_push_beat = {r_hold_sop, 1'b0, 1'b0, r_hold_data};
            if (w_can_push) begin
               w_hold_sop_n = 1'b0;
            end else begin
               w_pkt_ovf_n = 1'b1;
               w_ovf_set   = 1'b1;
            end
            w_hold_data_n = i_rx_data;
         end
      end

      if (w_is_cmd && r_state != S_IDLE && w_ev == 2'b11) w_err_acc_n = 1'b1;

      if (w_end) begin
         w_err_val = w_err_acc_n | w_pkt_ovf_n;
         if (!w_drop_n && !r_term_pending && w_hold_valid_n) begin
            if (w_push) begin
               w_term_pending_n = 1'b1;
               w_term_err_n     = w_err_val;
            end else if (w_can_push) begin
               w_push         = 1'b1;
               w_push_beat    = {w_hold_sop_n, 1'b1, w_err_val, w_hold_data_n};
               w_hold_valid_n = 1'b0;
            end else begin
               w_term_pending_n = 1'b1;
               w_term_err_n     = 1'b1;
               w_ovf_set        = 1'b1;
            end
         end
         w_err_acc_n = 1'b0;
         w_pkt_ovf_n = 1'b0;
         w_drop_n    = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hold_valid   <= 1'b0;
         r_hold_sop     <= 1'b0;
         r_hold_data    <= 8'h00;
         r_err_acc      <= 1'b0;
         r_pkt_ovf      <= 1'b0;
         r_drop         <= 1'b0;
         r_term_pending <= 1'b0;
         r_term_err     <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
      end else begin
         r_hold_valid   <= w_hold_valid_n;
         r_hold_sop     <= w_hold_sop_n;
         r_hold_data    <= w_hold_data_n;
         r_err_acc      <= w_err_acc_n;
         r_pkt_ovf      <= w_pkt_ovf_n;
         r_drop         <= w_drop_n;
         r_term_pending <= w_term_pending_n;
         r_term_err     <= w_term_err_n;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_beat;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_linestate       <= 2'b00;
         r_vbus_state      <= 2'b00;
         r_rx_active       <= 1'b0;
         r_host_disconnect <= 1'b0;
         r_id_gnd          <= 1'b0;
         r_alt_int         <= 1'b0;
         r_overflow        <= 1'b0;
      end else begin
         r_alt_int <= w_is_cmd & i_rx_data[7];
         if (w_is_cmd) begin
            r_linestate       <= i_rx_data[1:0];
            r_vbus_state      <= i_rx_data[3:2];
            r_rx_active       <= w_ev[0];
            r_host_disconnect <= (w_ev == 2'b10);
            r_id_gnd          <= i_rx_data[6];
         end else if (i_rx_end) begin
            r_rx_active <= 1'b0;
         end else if (w_is_data) begin
            r_rx_active <= 1'b1;
         end
         if (w_ovf_set)           r_overflow <= 1'b1;
         else if (i_overflow_clr) r_overflow <= 1'b0;
      end
   end

   assign w_head            = r_mem[r_rd_ptr];
   assign o_pkt_valid       = (r_count != '0);
   assign o_pkt_data        = o_pkt_valid ? w_head[7:0] : 8'h00;
   assign o_pkt_err         = o_pkt_valid & w_head[8];
   assign o_pkt_eop         = o_pkt_valid & w_head[9];
   assign o_pkt_sop         = o_pkt_valid & w_head[10];
   assign o_linestate       = r_linestate;
   assign o_vbus_state      = r_vbus_state;
   assign o_rx_active       = r_rx_active;
   assign o_host_disconnect = r_host_disconnect;
   assign o_id_gnd          = r_id_gnd;
   assign o_alt_int         = r_alt_int;
   assign o_overflow        = r_overflow;
endmodule

// File: tb/tb_ulpi_rx_framer.sv
// tb/tb_ulpi_rx_framer.sv - self-checking bench for ulpi_rx_framer: RX CMD decode table and scoreboarded packet beats.
module tb_ulpi_rx_framer;
   logic       clk = 1'b0;
   logic       reset, rx_valid, rx_cmd, rx_end, pkt_ready, overflow_clr;
   logic [7:0] rx_data;
   logic [7:0] pkt_data;
   logic       pkt_sop, pkt_eop, pkt_err, pkt_valid;
   logic [1:0] linestate, vbus_state;
   logic       rx_active, host_disconnect, id_gnd, alt_int, overflow;

   int n_checks = 0;
   int n_fail   = 0;
   logic [10:0] exp_q[$];
   logic [10:0] exp_beat;

   typedef struct {
      logic [7:0] cmd;
      logic [1:0] ls;
      logic [1:0] vb;
      logic       act;
      logic       hd;
      logic       id;
      logic       alt;
   } vec_t;
   vec_t vecs[6];

   ulpi_rx_framer #(.DEPTH(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_rx_valid(rx_valid), .i_rx_cmd(rx_cmd), .i_rx_data(rx_data),
      .i_rx_end(rx_end), .o_pkt_data(pkt_data), .o_pkt_sop(pkt_sop), .o_pkt_eop(pkt_eop),
      .o_pkt_err(pkt_err), .o_pkt_valid(pkt_valid), .i_pkt_ready(pkt_ready), .o_linestate(linestate),
      .o_vbus_state(vbus_state), .o_rx_active(rx_active), .o_host_disconnect(host_disconnect),
      .o_id_gnd(id_gnd), .o_alt_int(alt_int), .o_overflow(overflow), .i_overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Beats are consumed at the next posedge; compare them here, half a cycle earlier.
   always @(negedge clk) begin
      if (!reset && pkt_valid && pkt_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none", {pkt_sop, pkt_eop, pkt_err, pkt_data});
         end else begin
            exp_beat = exp_q.pop_front();
            check("beat", {21'd0, pkt_sop, pkt_eop, pkt_err, pkt_data}, {21'd0, exp_beat});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      rx_valid = 1'b1; rx_cmd = 1'b1; rx_data = b;
      tick();
      rx_valid = 1'b0; rx_cmd = 1'b0; rx_data = 8'h00;
   endtask

   task automatic send_data(input logic [7:0] b, input logic with_end);
      rx_valid = 1'b1; rx_cmd = 1'b0; rx_data = b; rx_end = with_end;
      tick();
      rx_valid = 1'b0; rx_data = 8'h00; rx_end = 1'b0;
   endtask

   task automatic end_pulse();
      rx_end = 1'b1;
      tick();
      rx_end = 1'b0;
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         tick();
         k++;
      end
      check(name, exp_q.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h42, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h10, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h2D, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h87, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h70, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};

      reset = 1'b1; rx_valid = 1'b0; rx_cmd = 1'b0; rx_end = 1'b0; rx_data = 8'h00;
      pkt_ready = 1'b1; overflow_clr = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {pkt_valid, pkt_sop, pkt_eop, pkt_err, pkt_data, linestate, vbus_state,
                              rx_active, host_disconnect, id_gnd, alt_int, overflow}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         send_cmd(vecs[i].cmd);
         check($sformatf("status_cmd_%02h", vecs[i].cmd),
               {pkt_valid, linestate, vbus_state, rx_active, host_disconnect, id_gnd, alt_int},
               {1'b0, vecs[i].ls, vecs[i].vb, vecs[i].act, vecs[i].hd, vecs[i].id, vecs[i].alt});
      end
      send_cmd(8'h00);
      tick();
      check("no_beat_from_cmds", pkt_valid, 1'b0);

      // Armed packet of four bytes terminated by rx_end.
      send_cmd(8'h10);
      exp_q.push_back({3'b100, 8'hA1});
      exp_q.push_back({3'b000, 8'hB2});
      exp_q.push_back({3'b000, 8'hC3});
      exp_q.push_back({3'b010, 8'hD4});
      send_data(8'hA1, 1'b0);
      send_data(8'hB2, 1'b0);
      send_data(8'hC3, 1'b0);
      send_data(8'hD4, 1'b0);
      end_pulse();
      check("rx_active_after_end", rx_active, 1'b0);
      drain("pkt_armed_drain");

      // Implicit RxActive packet ended by RX CMD after RxError.
      exp_q.push_back({3'b100, 8'h01});
      exp_q.push_back({3'b000, 8'h02});
      exp_q.push_back({3'b000, 8'h03});
      exp_q.push_back({3'b011, 8'h04});
      send_data(8'h01, 1'b0);
      check("implicit_rx_active", rx_active, 1'b1);
      send_data(8'h02, 1'b0);
      send_data(8'h03, 1'b0);
      send_data(8'h04, 1'b0);
      send_cmd(8'hF0);
      check("alt_int_pulse_high", alt_int, 1'b1);
      tick();
      check("alt_int_pulse_low", alt_int, 1'b0);
      send_cmd(8'h00);
      drain("pkt_rxerror_drain");

      // One-byte packet with rx_end coincident with the byte.
      exp_q.push_back({3'b110, 8'h5A});
      send_data(8'h5A, 1'b1);
      drain("pkt_single_drain");

      // Overflow: seven bytes into a four-entry FIFO with the consumer stalled.
      pkt_ready = 1'b0;
      for (int i = 0; i < 7; i++) send_data(8'hE0 + 8'(i), 1'b0);
      end_pulse();
      tick();
      check("overflow_set", overflow, 1'b1);
      check("head_held", {pkt_valid, pkt_sop, pkt_eop, pkt_data}, {3'b110, 8'hE0});
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0) ? 3'b100 : 3'b000, 8'hE0 + 8'(i)});
      exp_q.push_back({3'b011, 8'hE5});
      pkt_ready = 1'b1;
      drain("pkt_overflow_drain");
      check("overflow_sticky", overflow, 1'b1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("overflow_cleared", overflow, 1'b0);

      // Reset mid-packet discards the partial packet.
      pkt_ready = 1'b0;
      send_cmd(8'h87);
      send_data(8'h11, 1'b0);
      send_data(8'h22, 1'b0);
      check("pre_reset_beat", pkt_valid, 1'b1);
      reset = 1'b1;
      tick();
      check("reset_mid_packet", {pkt_valid, linestate, vbus_state, rx_active, id_gnd, alt_int, overflow}, 32'd0);
      reset = 1'b0;
      pkt_ready = 1'b1;
      tick();
      tick();
      check("no_stale_beat", pkt_valid, 1'b0);
      send_cmd(8'h10);
      exp_q.push_back({3'b100, 8'h33});
      exp_q.push_back({3'b010, 8'h44});
      send_data(8'h33, 1'b0);
      send_data(8'h44, 1'b0);
      end_pulse();
      drain("pkt_after_reset_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
